mux_rr_n_a_1: RTL and testbench

// - Parametrised N-channel to 1 multiplexer with valid/ready handshake on every channel and a registered output.
// - Two modes: fixed select (channel chosen by i_sel) or round-robin arbitration among valid channels.
// - Sits between several data producers and a single consumer. Merges the streams without loss.
// - Output tags each word with its source channel.

---
 rtl/mux_rr_n_a_1_if.sv | 28 ++
 rtl/mux_rr_n_a_1.sv | 82 ++++++++
 tb/tb_mux_rr_n_a_1.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mux_rr_n_a_1_if.sv
// Stream bundle for the N-channel to 1 mux: per-channel inputs, mode/select, and the
// registered output stream. Signal names are from the mux's point of view.
interface mux_rr_n_a_1_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 4
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic [N_CH*DATA_W-1:0] i_datos;
  logic [N_CH-1:0]        i_valid;
  logic [N_CH-1:0]        o_ready;
  logic                   i_modo;
  logic [SEL_W-1:0]       i_sel;
  logic [DATA_W-1:0]      o_datos;
  logic [SEL_W-1:0]       o_canal;
  logic                   o_valid;
  logic                   i_ready;

  modport slave (
    input  i_datos, i_valid, i_modo, i_sel, i_ready,
    output o_ready, o_datos, o_canal, o_valid
  );

  modport master (
    output i_datos, i_valid, i_modo, i_sel, i_ready,
    input  o_ready, o_datos, o_canal, o_valid
  );
endinterface

// File: rtl/mux_rr_n_a_1.sv
// N-channel to 1 stream mux with fixed-select or round-robin arbitration and a single
// registered output stage tagged with the source channel.
module mux_rr_n_a_1 #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 4
) (
  input logic           i_clk,
  input logic           i_rst_n,
  mux_rr_n_a_1_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  canal_q, canal_d;
  logic [DATA_W-1:0] datos_q, datos_d;
  logic [SEL_W-1:0]  g;
  logic              grant_ok;
  logic              load;
  logic [N_CH-1:0]   ready;

  // Grant. Round-robin scans from the far end so the nearest valid channel after ptr wins.
  always_comb begin
    g        = '0;
    grant_ok = 1'b0;
    if (!bus.i_modo) begin
      if (int'(bus.i_sel) < int'(N_CH)) begin
        g        = bus.i_sel;
        grant_ok = bus.i_valid[bus.i_sel];
      end
    end else begin
      for (int off = int'(N_CH); off >= 1; off--) begin
        if (bus.i_valid[(int'(ptr_q) + off) % int'(N_CH)]) begin
          g        = SEL_W'((int'(ptr_q) + off) % int'(N_CH));
          grant_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    canal_d = canal_q;
    datos_d = datos_q;
    ready   = '0;
    // Gating with reset keeps every o_ready low while reset is held.
    load    = grant_ok && i_rst_n && ((state_q == StEmpty) || bus.i_ready);
    if (load) begin
      ready[g] = 1'b1;
      datos_d  = bus.i_datos[int'(g)*DATA_W +: DATA_W];
      canal_d  = g;
      if (bus.i_modo) ptr_d = g;
    end
    unique case (state_q)
      StEmpty: if (load) state_d = StFull;
      StFull:  if (bus.i_ready && !load) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StEmpty;
      ptr_q   <= SEL_W'(N_CH - 1);
      canal_q <= '0;
      datos_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      canal_q <= canal_d;
      datos_q <= datos_d;
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = (state_q == StFull);
  assign bus.o_datos = datos_q;
  assign bus.o_canal = canal_q;
endmodule

// File: tb/tb_mux_rr_n_a_1.sv
// Directed bench for mux_rr_n_a_1: a small arbitration model predicts o_ready and pushes each
// accepted word to a scoreboard that is checked against the output register.
module tb_mux_rr_n_a_1;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [5:0] sb[$];
  logic       m_valid;
  logic [1:0] m_ptr;

  mux_rr_n_a_1_if #(.N_CH(4), .DATA_W(4)) bus ();

  mux_rr_n_a_1 #(.N_CH(4), .DATA_W(4)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare at the falling edge, then advance the model across the next rising edge.
  task automatic step();
    logic [1:0]  eg;
    logic        gok;
    logic        ld;
    logic [15:0] sh;
    @(negedge clk);
    chk("o_valid", 32'(bus.o_valid), 32'(m_valid));
    if (m_valid) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_underrun observed=empty expected=entry");
      end
      if (sb.size() != 0) begin
        chk("o_datos", 32'(bus.o_datos), 32'(sb[0][3:0]));
        chk("o_canal", 32'(bus.o_canal), 32'(sb[0][5:4]));
        if (bus.i_ready) void'(sb.pop_front());
      end
    end
    eg  = 2'd0;
    gok = 1'b0;
    if (!bus.i_modo) begin
      eg  = bus.i_sel;
      gok = bus.i_valid[bus.i_sel];
    end else begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (int'(m_ptr) + i) % N;
        if (!gok && bus.i_valid[k]) begin
          eg  = 2'(k);
          gok = 1'b1;
        end
      end
    end
    ld = gok && (!m_valid || bus.i_ready);
    chk("o_ready", 32'(bus.o_ready), ld ? (32'd1 << eg) : 32'd0);
    if (ld) begin
      sh = bus.i_datos >> (4 * int'(eg));
      sb.push_back({eg, sh[3:0]});
      if (bus.i_modo) m_ptr = eg;
    end
    m_valid = ld ? 1'b1 : (bus.i_ready ? 1'b0 : m_valid);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.i_datos = '0;
    bus.i_valid = '0;
    bus.i_modo  = 1'b0;
    bus.i_sel   = '0;
    bus.i_ready = 1'b1;
    m_valid     = 1'b0;
    m_ptr       = 2'd3;

    // Reset, then idle
    repeat (2) @(posedge clk);
    #2;
    chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_o_ready", 32'(bus.o_ready), 32'd0);
    chk("rst_o_datos", 32'(bus.o_datos), 32'd0);
    chk("rst_o_canal", 32'(bus.o_canal), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_o_datos", 32'(bus.o_datos), 32'd0);
    end

    // Fixed select on channel 2, other channels also valid but never readied
    bus.i_sel   = 2'd2;
    bus.i_datos = 16'h0A00;
    bus.i_valid = 4'b0100;
    step();
    bus.i_datos = 16'h4A21;
    bus.i_valid = 4'b1111;
    step();
    step();

    // Round-robin, all channels valid: strict rotation
    bus.i_modo  = 1'b1;
    bus.i_datos = 16'h4321;
    repeat (8) step();
    bus.i_valid = 4'b0000;
    repeat (2) step();

    // Backpressure with channel 1 valid, then drain and load in the same cycle
    bus.i_valid = 4'b0010;
    bus.i_datos = 16'h0500;
    bus.i_datos[7:4] = 4'h7;
    step();
    bus.i_ready = 1'b0;
    bus.i_datos[7:4] = 4'h9;
    repeat (3) step();
    bus.i_ready = 1'b1;
    step();
    bus.i_valid = 4'b0000;
    repeat (2) step();

    // Move pointer to 3, then channels 0 and 3 alternate across the wrap
    bus.i_datos = 16'hC00B;
    bus.i_valid = 4'b1000;
    step();
    bus.i_valid = 4'b1001;
    repeat (4) step();
    bus.i_valid = 4'b1000;
    repeat (3) step();
    bus.i_valid = 4'b0000;
    repeat (2) step();

    // Asynchronous reset while full mid-stream
    bus.i_datos = 16'h8642;
    bus.i_valid = 4'b1111;
    repeat (2) step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_o_valid", 32'(bus.o_valid), 32'd0);
    chk("arst_o_ready", 32'(bus.o_ready), 32'd0);
    sb.delete();
    m_valid = 1'b0;
    m_ptr   = 2'd3;
    @(posedge clk);
    #2;
    chk("arst_hold_o_valid", 32'(bus.o_valid), 32'd0);
    rst_n = 1'b1;
    repeat (5) step();
    bus.i_valid = 4'b0000;
    repeat (2) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
